// File: rtl/d_flipflop_pkg.sv
// Shared constants and types for the d_flipflop storage primitive.
// Instances override width and reset value through parameters; these are the defaults.
package d_flipflop_pkg;

    localparam int DEFAULT_WIDTH = 1;

    typedef logic [DEFAULT_WIDTH-1:0] data_t;

    localparam data_t DEFAULT_RESET_VAL = '0;

endpackage

// File: rtl/d_flipflop_if.sv
// Data/enable/output bundle of one d_flipflop instance.
// The master drives D and en; the slave (the flop) returns q and qbar.
interface d_flipflop_if
    import d_flipflop_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] D;
    logic             en;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;

    modport master (
        output D,
        output en,
        input  q,
        input  qbar
    );

    modport slave (
        input  D,
        input  en,
        output q,
        output qbar
    );

endinterface

// File: rtl/d_flipflop.sv
// Enabled D-type register with asynchronous active-high reset and complementary outputs.
// Each of the WIDTH bits is independent but shares clk, rst and en.
module d_flipflop
    import d_flipflop_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
    input  logic         clk,
    input  logic         rst,
    d_flipflop_if.slave  bus
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else if (bus.en) begin
            r_q <= bus.D;
        end
    end

    // qbar comes from the stored state so it can never disagree with q.
    assign bus.q    = r_q;
    assign bus.qbar = ~r_q;

endmodule

// File: tb/tb_d_flipflop.sv
// Bench for d_flipflop: a 1-bit and an 8-bit (reset value A5) instance driven together.
// Expected q is the last D loaded since the most recent reset, or the reset value if none.
module tb_d_flipflop;

    logic clk;
    logic rst;

    d_flipflop_if #(.WIDTH(1)) if1 ();
    d_flipflop_if #(.WIDTH(8)) if8 ();

    d_flipflop #(.WIDTH(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    d_flipflop #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: history of words loaded since the last reset.
    logic       h1[$];
    logic [7:0] h8[$];

    function automatic logic exp1();
        return (h1.size() == 0) ? 1'b0 : h1[h1.size()-1];
    endfunction

    function automatic logic [7:0] exp8();
        return (h8.size() == 0) ? 8'hA5 : h8[h8.size()-1];
    endfunction

    task automatic set_rst(input logic v);
        rst = v;
        if (v) begin
            h1.delete();
            h8.delete();
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        logic e1;
        logic [7:0] e8;
        e1 = exp1();
        e8 = exp8();
        $display("t=%0t %s rst=%b en1=%b D1=%b q1=%b en8=%b D8=%h q8=%h", $time, tag,
                 rst, if1.en, if1.D, if1.q, if8.en, if8.D, if8.q);
        chk({tag, "_q1"},    {7'b0, if1.q},    {7'b0, e1});
        chk({tag, "_qbar1"}, {7'b0, if1.qbar}, {7'b0, ~e1});
        chk({tag, "_q8"},    if8.q,    e8);
        chk({tag, "_qbar8"}, if8.qbar, ~e8);
    endtask

    // Advance to the next rising edge, record what the flop should capture, sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (if1.en) h1.push_back(if1.D);
            if (if8.en) h8.push_back(if8.D);
        end
        #1;
    endtask

    initial begin
        rst    = 1'b0;
        if1.D  = 1'b1;
        if1.en = 1'b1;
        if8.D  = 8'h3C;
        if8.en = 1'b1;
        #2;
        // Reset asserted with no clock edge yet
        set_rst(1'b1);
        #1;
        check_all("rst_async");
        chk("rst_q8_const", if8.q, 8'hA5);
        chk("rst_qbar8_const", if8.qbar, 8'h5A);
        tick();
        check_all("rst_edge");
        chk("rst_edge_q1_const", {7'b0, if1.q}, 8'h00);
        @(negedge clk);
        set_rst(1'b0);
        if8.en = 1'b0;
        #1;
        check_all("rst_release");
        tick();
        check_all("first_load");
        chk("first_load_q1_const", {7'b0, if1.q}, 8'h01);

        // Hold: reset again, then en=0 with D=1 across three edges
        @(negedge clk);
        set_rst(1'b1);
        #1;
        check_all("rst_midop");
        @(negedge clk);
        set_rst(1'b0);
        if1.en = 1'b0;
        if1.D  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("hold");
        end

        // Load sequence en/D = 0/0, 1/0, 0/1, 1/1; the 8-bit load and hold ride along
        if1.en = 1'b0; if1.D = 1'b0;
        tick(); check_all("seq_00");
        if1.en = 1'b1; if1.D = 1'b0;
        if8.en = 1'b1; if8.D = 8'h3C;
        tick(); check_all("seq_10");
        chk("load_q8_const", if8.q, 8'h3C);
        chk("load_qbar8_const", if8.qbar, 8'hC3);
        if1.en = 1'b0; if1.D = 1'b1;
        if8.en = 1'b0; if8.D = 8'hFF;
        tick(); check_all("seq_01");
        chk("hold_q8_const", if8.q, 8'h3C);
        if1.en = 1'b1; if1.D = 1'b1;
        tick(); check_all("seq_11");
        chk("seq_11_q1_const", {7'b0, if1.q}, 8'h01);

        // Async reset 5 ns after an edge, then an edge while rst is still high with en=1, D=1
        if8.en = 1'b1; if8.D = 8'h77;
        tick(); check_all("pre_async");
        #4;
        set_rst(1'b1);
        #1;
        check_all("async_mid");
        chk("async_mid_q1_const", {7'b0, if1.q}, 8'h00);
        tick();
        check_all("edge_in_rst");
        @(negedge clk);
        set_rst(1'b0);

        // D glitch strictly between edges with en=1
        if1.en = 1'b1; if1.D = 1'b0;
        if8.en = 1'b0;
        tick(); check_all("glitch_setup");
        #3 if1.D = 1'b1;
        #4 if1.D = 1'b0;
        tick(); check_all("glitch_edge1");
        tick(); check_all("glitch_edge2");

        // Randomized traffic with occasional asynchronous reset pulses
        for (int i = 0; i < 60; i++) begin
            if1.en = 1'($urandom_range(0, 1));
            if1.D  = 1'($urandom_range(0, 1));
            if8.en = 1'($urandom_range(0, 1));
            if8.D  = 8'($urandom_range(0, 255));
            if (rst && $urandom_range(0, 2) == 0) set_rst(1'b0);
            else if (!rst && $urandom_range(0, 11) == 0) set_rst(1'b1);
            #1;
            check_all("rnd_between");
            tick();
            check_all("rnd_edge");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
